// File: rtl/hex_status_pkg.sv
// Shared types and constants for the six-digit status display controller.
package hex_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FOUND  = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  typedef logic [4:0] char_t;

  localparam char_t       CHAR_DASH  = 5'h10;
  localparam char_t       CHAR_BLANK = 5'h1F;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned KEY_W      = 24;
  localparam int unsigned SEG_W      = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Target state of an event cycle; clear > found > fail > start.
  function automatic state_t evt_target(input logic clear, input logic found,
                                        input logic fail, input logic start,
                                        input state_t cur);
    state_t nxt;
    nxt = cur;
    if (clear)      nxt = ST_IDLE;
    else if (found) nxt = ST_FOUND;
    else if (fail)  nxt = ST_FAIL;
    else if (start) nxt = ST_SEARCH;
    return nxt;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational char-code to active-low {g,f,e,d,c,b,a} segment encoder.
module seg7_encode
  import hex_status_pkg::*;
(
  input  char_t            char_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (char_i)
      5'h00:     seg_o = 7'h40;
      5'h01:     seg_o = 7'h79;
      5'h02:     seg_o = 7'h24;
      5'h03:     seg_o = 7'h30;
      5'h04:     seg_o = 7'h19;
      5'h05:     seg_o = 7'h12;
      5'h06:     seg_o = 7'h02;
      5'h07:     seg_o = 7'h78;
      5'h08:     seg_o = 7'h00;
      5'h09:     seg_o = 7'h10;
      5'h0A:     seg_o = 7'h08;
      5'h0B:     seg_o = 7'h03;
      5'h0C:     seg_o = 7'h46;
      5'h0D:     seg_o = 7'h21;
      5'h0E:     seg_o = 7'h06;
      5'h0F:     seg_o = 7'h0E;
      CHAR_DASH: seg_o = 7'h3F;
      default:   seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_status_ctrl.sv
// Sequences HEX5..HEX0 from search-engine event pulses: blank, sweeping dash,
// found key in hex, or blinking dashes on failure.
module hex_status_ctrl
  import hex_status_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             found,
  input  logic [KEY_W-1:0] key,
  input  logic             fail,
  input  logic             clear,
  output logic [1:0]       state_o,
  output logic [SEG_W-1:0] HEX0,
  output logic [SEG_W-1:0] HEX1,
  output logic [SEG_W-1:0] HEX2,
  output logic [SEG_W-1:0] HEX3,
  output logic [SEG_W-1:0] HEX4,
  output logic [SEG_W-1:0] HEX5
);

  localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       POS_MAX = 3'(NUM_DIGITS - 1);

  state_t             state_q;
  state_t             evt_state;
  logic               evt;
  logic               tick;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2:0]         pos_q,   pos_d;
  logic               phase_q, phase_d;
  char_t              chars   [NUM_DIGITS];
  logic [SEG_W-1:0]   seg     [NUM_DIGITS];
  logic [SEG_W-1:0]   hex_q   [NUM_DIGITS];

  // Every pulse is an accepted event, even when it re-enters the same state.
  always_comb begin
    evt       = clear | found | fail | start;
    evt_state = evt_target(clear, found, fail, start, state_q);
    tick      = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (evt) begin
      state_q <= evt_state;
    end
  end

  always_comb begin
    key_d   = key_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    pos_d   = pos_q;
    phase_d = phase_q;
    if (found && !clear) key_d = key;
    if (evt) begin
      cnt_d   = '0;
      pos_d   = '0;
      phase_d = (evt_state == ST_FAIL);
    end else if (tick) begin
      if (state_q == ST_SEARCH) pos_d = (pos_q == POS_MAX) ? 3'd0 : pos_q + 3'd1;
      if (state_q == ST_FAIL)   phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  // Per-digit character selection from the current display state.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      chars[i] = CHAR_BLANK;
      case (state_q)
        ST_SEARCH: if (pos_q == 3'(i)) chars[i] = CHAR_DASH;
        ST_FOUND:  chars[i] = {1'b0, key_q[4*i +: 4]};
        ST_FAIL:   if (phase_q) chars[i] = CHAR_DASH;
        default:   chars[i] = CHAR_BLANK;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_encode u_enc (
      .char_i (chars[g]),
      .seg_o  (seg[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_OFF;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= seg[i];
    end
  end

  assign state_o = state_q;
  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign HEX4    = hex_q[4];
  assign HEX5    = hex_q[5];

endmodule

// File: tb/tb_hex_status_ctrl.sv
// Scoreboard bench for hex_status_ctrl with TICK_DIV=4.
module tb_hex_status_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, found, fail, clear;
  logic [23:0] key;
  logic [1:0]  state_o;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0] hex_all;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  st;
    logic [41:0] hx;
    string       tag;
  } exp_t;
  exp_t sb[$];

  localparam logic [6:0]  B     = 7'h7F;
  localparam logic [6:0]  D     = 7'h3F;
  localparam logic [41:0] ALL_B = {6{B}};
  localparam logic [41:0] ALL_D = {6{D}};
  // {HEX5..HEX0} for keys A3F09C, 123456 and DEB789
  localparam logic [41:0] KEY_A = {7'h08, 7'h30, 7'h0E, 7'h40, 7'h10, 7'h46};
  localparam logic [41:0] KEY_1 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] KEY_2 = {7'h21, 7'h06, 7'h03, 7'h78, 7'h00, 7'h10};

  hex_status_ctrl #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .found   (found),
    .key     (key),
    .fail    (fail),
    .clear   (clear),
    .state_o (state_o),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .HEX4    (HEX4),
    .HEX5    (HEX5)
  );

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  function automatic logic [41:0] dash_at(input int p);
    logic [41:0] r;
    r = ALL_B;
    r[7*p +: 7] = D;
    return r;
  endfunction

  // Consumer: one expectation per clock edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st) begin
          errors++;
          $display("FAIL %s state_o: got %0d expected %0d", e.tag, state_o, e.st);
        end
        checks++;
        if (hex_all !== e.hx) begin
          errors++;
          $display("FAIL %s hex: got %h expected %h", e.tag, hex_all, e.hx);
        end
      end
    end
  end

  // Push the expectation for the coming edge, run the edge, drop one-cycle pulses.
  task automatic step(input logic [1:0] st, input logic [41:0] hx, input string tag);
    exp_t e;
    e.st = st; e.hx = hx; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #2;
    start = 1'b0; found = 1'b0; fail = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; found = 1'b0; fail = 1'b0; clear = 1'b0; key = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++;
    if (hex_all !== ALL_B) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex_all, ALL_B); end
    rst_n = 1'b1;
    repeat (2) step(2'd0, ALL_B, "idle_after_reset");
    start = 1'b1;
    step(2'd1, ALL_B, "rst_start_edge");
    repeat (2) step(2'd1, dash_at(0), "rst_sweep");
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", state_o); end
    checks++;
    if (hex_all !== ALL_B) begin errors++; $display("FAIL async_reset_hex: got %h expected %h", hex_all, ALL_B); end
    @(posedge clk);
    #2;
    checks++;
    if (hex_all !== ALL_B) begin errors++; $display("FAIL held_reset_hex: got %h expected %h", hex_all, ALL_B); end
    rst_n = 1'b1;
    repeat (3) step(2'd0, ALL_B, "resume_idle");
  endtask

  task automatic test_search_sweep();
    start = 1'b1;
    step(2'd1, ALL_B, "sweep_start_edge");
    for (int k = 0; k < 7; k++)
      repeat (4) step(2'd1, dash_at(k % 6), $sformatf("sweep_pos%0d", k % 6));
    clear = 1'b1;
    step(2'd0, dash_at(1), "sweep_clear_edge");
    step(2'd0, ALL_B, "sweep_cleared");
  endtask

  task automatic test_found();
    found = 1'b1; key = 24'hA3F09C;
    step(2'd2, ALL_B, "found_edge");
    key = 24'h555555;
    repeat (5) step(2'd2, KEY_A, "found_key");
    start = 1'b1;
    step(2'd1, KEY_A, "found_restart_edge");
    repeat (4) step(2'd1, dash_at(0), "found_resweep0");
    step(2'd1, dash_at(1), "found_resweep1");
    clear = 1'b1;
    step(2'd0, dash_at(1), "found_clear_edge");
    step(2'd0, ALL_B, "found_cleared");
  endtask

  task automatic test_fail_blink();
    fail = 1'b1;
    step(2'd3, ALL_B, "fail_edge");
    for (int k = 0; k < 4; k++)
      repeat (4) step(2'd3, (k % 2 == 0) ? ALL_D : ALL_B, $sformatf("blink%0d", k));
    clear = 1'b1;
    step(2'd0, ALL_D, "fail_clear_edge");
    step(2'd0, ALL_B, "fail_cleared");
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL fail_clear_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_simultaneous();
    found = 1'b1; fail = 1'b1; key = 24'h123456;
    step(2'd2, ALL_B, "found_fail_edge");
    repeat (2) step(2'd2, KEY_1, "found_fail_key");
    clear = 1'b1; found = 1'b1; key = 24'hFFFFFF;
    step(2'd0, KEY_1, "clear_found_edge");
    repeat (2) step(2'd0, ALL_B, "clear_found_idle");
    found = 1'b1; key = 24'hDEB789;
    step(2'd2, ALL_B, "new_found_edge");
    repeat (2) step(2'd2, KEY_2, "new_found_key");
    fail = 1'b1; start = 1'b1;
    step(2'd3, KEY_2, "fail_start_edge");
    repeat (2) step(2'd3, ALL_D, "fail_start_blink");
    clear = 1'b1;
    step(2'd0, ALL_D, "simul_clear_edge");
    step(2'd0, ALL_B, "simul_cleared");
  endtask

  task automatic test_restart();
    start = 1'b1;
    step(2'd1, ALL_B, "rs_start_edge");
    for (int k = 0; k < 3; k++)
      repeat (4) step(2'd1, dash_at(k), $sformatf("rs_pos%0d", k));
    step(2'd1, dash_at(3), "rs_pos3");
    start = 1'b1;
    step(2'd1, dash_at(3), "rs_restart_edge");
    repeat (4) step(2'd1, dash_at(0), "rs_back0");
    step(2'd1, dash_at(1), "rs_move_after4");
    for (int k = 0; k < 6; k++) begin
      start = 1'b1;
      step(2'd1, (k == 0) ? dash_at(1) : dash_at(0), "held_start");
    end
    repeat (4) step(2'd1, dash_at(0), "held_release0");
    step(2'd1, dash_at(1), "held_release1");
    clear = 1'b1;
    step(2'd0, dash_at(1), "rs_clear_edge");
    step(2'd0, ALL_B, "rs_cleared");
  endtask

  initial begin
    test_reset();
    test_search_sweep();
    test_found();
    test_fail_blink();
    test_simultaneous();
    test_restart();
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_status_ctrl.md
# hex_status_ctrl

Display controller for the six on-board seven-segment digits (HEX5..HEX0) of the key-search design. It takes one-cycle event pulses from the search engine (start, found-with-key, fail, clear) and sequences the display. States are: blank, an animated sweeping dash while searching, the 24-bit found key in hex, or blinking dashes on failure. It owns all six digit encoders, so no other block drives the HEX pins.

## Interface
- `TICK_DIV`, default 12_500_000: clock cycles per animation tick (4 Hz at 50 MHz); legal range 2..2^24.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: one-cycle pulse; search begun.
- `found` input, 1 bit: one-cycle pulse; key valid on `key` in the same cycle.
- `key` input, 24 bits: recovered key, sampled only when `found`=1.
- `fail` input, 1 bit: one-cycle pulse; keyspace exhausted.
- `clear` input, 1 bit: one-cycle pulse; return to blank.
- `state_o` output, 2 bits: current state encoding (IDLE=0, SEARCH=1, FOUND=2, FAIL=3).
- `HEX0`..`HEX5` output, 7 bits each: active-low segments `{g,f,e,d,c,b,a}`; HEX0 is the rightmost digit.

## Operation
- Event priority when several events pulse in one cycle: `clear` > `found` > `fail` > `start`.
- State transitions:
  - IDLE: `start` goes to SEARCH; `found` goes to FOUND; `fail` goes to FAIL.
  - SEARCH: `found` goes to FOUND; `fail` goes to FAIL; `start` restarts SEARCH (sweep position goes back to 0).
  - FOUND and FAIL: `start` goes to SEARCH; `found` in FOUND latches the new key; `fail` in FAIL restarts the blink phase.
  - Any state: `clear` goes to IDLE.
- `found` latches `key` into `key_q` in the same edge as the state change. `key_q` holds until the next `found` or reset.
- Tick counter `cnt`:
  - Counts 0..TICK_DIV-1; `tick`=1 when `cnt`==TICK_DIV-1, then `cnt` wraps to 0.
  - `cnt` is forced to 0 on every accepted event, including a restart into the same state.
- Per-digit character selection, using 5-bit char codes:
  - IDLE: all digits BLANK.
  - SEARCH: digit `pos` shows DASH, all others BLANK. `pos` is 0 on entry, increments on each `tick`, and wraps from 5 to 0.
  - FOUND: digit i shows `key_q[4i+3:4i]` as 0..F, so HEX5 holds the MSN.
  - FAIL: all digits show DASH when `phase`=1, all BLANK when `phase`=0. `phase` is 1 on entry and toggles on each `tick`.
- Char codes: 0x00..0x0F are hex digits, 0x10 is DASH, 0x1F is BLANK. Any other code is driven as BLANK.
- Segment patterns are active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
  - DASH=3F, BLANK=7F

## Timing
- Reset (asynchronous, while `rst_n`=0) sets: state IDLE, `state_o`=0, `cnt`=0, `pos`=0, `phase`=0, `key_q`=0, all HEX=7'h7F.
- Reset released mid-animation resumes in IDLE; no pending event is remembered.
- Event sampled at edge N: `state_o` changes at edge N, and the HEX outputs are registered so they change at edge N+1. Input-to-pin latency is 2 edges from the pulse cycle.
- The first `tick` after entering a state comes TICK_DIV cycles after the entry edge.
- `state_o` is registered and glitch-free; HEX outputs come straight from flops.
- Input pulses longer than one cycle are re-accepted every cycle. A held `start` therefore keeps `pos` at 0.

## Structure
- Package `hex_status_pkg` holds:
  - the `state_t` enum (IDLE/SEARCH/FOUND/FAIL, 2 bits);
  - `char_t` (logic [4:0]);
  - constants `CHAR_DASH`=5'h10 and `CHAR_BLANK`=5'h1F.
- Sub-module `seg7_encode` (char_t in, 7-bit active-low out) is purely combinational and instantiated six times. Its outputs feed the HEX output registers.
- The top level contains the state register, `key_q`, `cnt`, `pos` and `phase` logic, and the per-digit char mux.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** assert `rst_n`=0 mid-SEARCH → all HEX=7F and `state_o`=0 immediately. Release reset → outputs stay the same.
- **Search sweep:** `start` pulse → 2 edges later HEX0=3F and the others 7F. Every 4 cycles the dash moves HEX0→HEX5, then wraps back to HEX0.
- **Found:** `found` with `key`=24'hA3F09C → HEX5..HEX0 = 08,30,0E,40,10,46. A later `start` returns to the sweep at HEX0.
- **Fail blink:** `fail` → all 3F for 4 cycles, then all 7F for 4 cycles, repeating. `clear` → all 7F, `state_o`=0.
- **Simultaneous events:** `found`+`fail` in one cycle → FOUND. `clear`+`found` → IDLE, and `key_q` stays unchanged (checked by a later `found` with a new key).
- **Restart:** `start` while in SEARCH at `pos`=3 → dash back at HEX0 2 edges later, and the next move comes exactly 4 cycles after the restart edge.
